// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: each accepted frame_tick runs one start/done pass over NUM_STAGES units.
// Optional per-stage watchdog is compiled in with `define STAGE_TIMEOUT_EN.
module frame_update_scheduler #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic                          enable,
  input  logic [NUM_STAGES-1:0]         stage_done,
  input  logic                          clear_status,
  output logic [NUM_STAGES-1:0]         stage_start,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic                          busy,
  output logic [FCNT_W-1:0]             frame_count,
  output logic                          overrun,
  output logic [7:0]                    overrun_count,
  output logic                          timeout_err
);

  localparam int unsigned   SW   = $clog2(NUM_STAGES);
  localparam int unsigned   OCW  = 8;
  localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

  // Elaboration-time guard on the supported configuration range.
  if (NUM_STAGES < 2 || NUM_STAGES > 8 || TIMEOUT < 2) begin : g_param_check
    $error("frame_update_scheduler: NUM_STAGES must be 2..8 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [SW-1:0]         r_cur,   w_cur_nxt;
  logic [NUM_STAGES-1:0] r_start, w_start_nxt;
  logic                  r_busy,  w_busy_nxt;
  logic [FCNT_W-1:0]     r_fcnt,  w_fcnt_nxt;
  logic                  r_ovr,   w_ovr_nxt;
  logic [OCW-1:0]        r_ocnt,  w_ocnt_nxt;
  logic                  w_done_cur;
  logic                  w_tmo_hit;
  logic                  w_advance;

  assign w_done_cur = stage_done[r_cur];

`ifdef STAGE_TIMEOUT_EN
  localparam int unsigned    WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] r_wdog;
  logic           r_tmo;

  // A done on the limit edge wins, so the timeout only fires without it.
  assign w_tmo_hit = (r_state == S_WAIT) && (r_wdog == WD_LAST) && !w_done_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_WAIT) ? r_wdog + WDW'(1) : '0;
      if (w_tmo_hit) begin
        r_tmo <= 1'b1;
      end else if (clear_status) begin
        r_tmo <= 1'b0;
      end
    end
  end

  assign timeout_err = r_tmo;
`else
  assign w_tmo_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign w_advance = w_done_cur | w_tmo_hit;

  // Next-state, pass bookkeeping and overrun status.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_fcnt_nxt  = r_fcnt;
    w_ovr_nxt   = r_ovr;
    w_ocnt_nxt  = r_ocnt;
    w_busy_nxt  = 1'b0;
    w_start_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (frame_tick && enable) begin
          w_state_nxt = S_START;
          w_cur_nxt   = '0;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_advance) begin
          if (r_cur == LAST) begin
            w_state_nxt = S_IDLE;
            w_fcnt_nxt  = r_fcnt + FCNT_W'(1);
          end else begin
            w_state_nxt = S_START;
            w_cur_nxt   = r_cur + SW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A dropped tick beats a simultaneous clear.
    if ((r_state != S_IDLE) && frame_tick) begin
      w_ovr_nxt = 1'b1;
      if (clear_status) begin
        w_ocnt_nxt = OCW'(1);
      end else if (r_ocnt != '1) begin
        w_ocnt_nxt = r_ocnt + OCW'(1);
      end
    end else if (clear_status) begin
      w_ovr_nxt  = 1'b0;
      w_ocnt_nxt = '0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_START) begin
      w_start_nxt = NUM_STAGES'(1) << w_cur_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_start <= '0;
      r_busy  <= 1'b0;
      r_fcnt  <= '0;
      r_ovr   <= 1'b0;
      r_ocnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_ovr   <= w_ovr_nxt;
      r_ocnt  <= w_ocnt_nxt;
    end
  end

  assign stage_start   = r_start;
  assign cur_stage     = r_cur;
  assign busy          = r_busy;
  assign frame_count   = r_fcnt;
  assign overrun       = r_ovr;
  assign overrun_count = r_ocnt;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: vector table plus hand sequences, scoreboard-compared.
// Timeout scenarios are exercised when STAGE_TIMEOUT_EN is defined.
module tb_frame_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       enable;
  logic [3:0] stage_done;
  logic       clear_status;
  logic [3:0] stage_start;
  logic [1:0] cur_stage;
  logic       busy;
  logic [15:0] frame_count;
  logic       overrun;
  logic [7:0] overrun_count;
  logic       timeout_err;

  always #5 clk = ~clk;

  frame_update_scheduler #(
    .NUM_STAGES(4),
    .TIMEOUT   (16),
    .FCNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .stage_done   (stage_done),
    .clear_status (clear_status),
    .stage_start  (stage_start),
    .cur_stage    (cur_stage),
    .busy         (busy),
    .frame_count  (frame_count),
    .overrun      (overrun),
    .overrun_count(overrun_count),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [3:0]  st;
    logic [1:0]  cu;
    logic        bu;
    logic [15:0] fc;
    logic        ov;
    logic [7:0]  oc;
    logic        tm;
  } exp_t;

  typedef struct {
    logic       t;
    logic       e;
    logic       c;
    logic [3:0] d;
    exp_t       x;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input int st, input int cu, input int bu, input int fc,
                              input int ov, input int oc, input int tm);
    exp_t x;
    x.st = 4'(st);
    x.cu = 2'(cu);
    x.bu = 1'(bu);
    x.fc = 16'(fc);
    x.ov = 1'(ov);
    x.oc = 8'(oc);
    x.tm = 1'(tm);
    return x;
  endfunction

  function automatic vec_t v(input int t, input int e, input int c, input int d,
                             input int st, input int cu, input int bu, input int fc,
                             input int ov, input int oc);
    vec_t r;
    r.t = 1'(t);
    r.e = 1'(e);
    r.c = 1'(c);
    r.d = 4'(d);
    r.x = mk(st, cu, bu, fc, ov, oc, 0);
    return r;
  endfunction

  task automatic cmp(input string nm, input string f, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %0h want %0h", nm, f, got, want);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic chk(input string nm);
    exp_t x;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", nm);
      return;
    end
    x = exp_q.pop_front();
    cmp(nm, "stage_start",   32'(stage_start),   32'(x.st));
    cmp(nm, "cur_stage",     32'(cur_stage),     32'(x.cu));
    cmp(nm, "busy",          32'(busy),          32'(x.bu));
    cmp(nm, "frame_count",   32'(frame_count),   32'(x.fc));
    cmp(nm, "overrun",       32'(overrun),       32'(x.ov));
    cmp(nm, "overrun_count", 32'(overrun_count), 32'(x.oc));
    cmp(nm, "timeout_err",   32'(timeout_err),   32'(x.tm));
  endtask

  task automatic cyc(input string nm, input int t, input int e, input int c, input int d, input exp_t x);
    frame_tick   = 1'(t);
    enable       = 1'(e);
    clear_status = 1'(c);
    stage_done   = 4'(d);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    chk(nm);
  endtask

  // From WAIT of stage s, return each done and expect the rest of the pass.
  task automatic finish_from(input string nm, input int s, input int e, input int fc,
                             input int ov, input int oc, input int tm);
    for (int k = s; k < 4; k++) begin
      if (k < 3) begin
        cyc(nm, 0, e, 0, 1 << k, mk(1 << (k + 1), k + 1, 1, fc, ov, oc, tm));
        cyc(nm, 0, e, 0, 0,      mk(0,            k + 1, 1, fc, ov, oc, tm));
      end else begin
        cyc(nm, 0, e, 0, 1 << k, mk(0, 3, 0, fc + 1, ov, oc, tm));
      end
    end
  endtask

  initial begin
    int oc;
    rst          = 1'b1;
    frame_tick   = 1'b0;
    enable       = 1'b0;
    stage_done   = '0;
    clear_status = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    chk("reset");
    rst = 1'b0;

    // Full pass, done 3 cycles after each start; early/foreign done bits ignored.
    vecs.push_back(v(1, 1, 0, 0,       'b0001, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0001,  0,      0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0010,  0,      0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,       0,      0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0001,  'b0010, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0010,  'b0100, 2, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(0, 1, 0, 0, 0, 2, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0100,  'b1000, 3, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(0, 1, 0, 0, 0, 3, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b1000,  0,      3, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,       0,      3, 0, 1, 0, 0));
    // Overrun in WAIT of stage 2, then on the last-done edge, then clear.
    vecs.push_back(v(1, 1, 0, 0,       'b0001, 0, 1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,       0,      0, 1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0001,  'b0010, 1, 1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,       0,      1, 1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 'b0010,  'b0100, 2, 1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,       0,      2, 1, 1, 0, 0));
    vecs.push_back(v(1, 1, 0, 0,       0,      2, 1, 1, 1, 1));
    vecs.push_back(v(0, 1, 0, 'b0100,  'b1000, 3, 1, 1, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,       0,      3, 1, 1, 1, 1));
    vecs.push_back(v(0, 1, 0, 'b1000,  0,      3, 0, 2, 1, 1));
    vecs.push_back(v(1, 1, 0, 0,       'b0001, 0, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,       0,      0, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 'b0001,  'b0010, 1, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,       0,      1, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 'b0010,  'b0100, 2, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,       0,      2, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 'b0100,  'b1000, 3, 1, 2, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,       0,      3, 1, 2, 1, 1));
    vecs.push_back(v(1, 1, 0, 'b1000,  0,      3, 0, 3, 1, 2));
    vecs.push_back(v(0, 1, 0, 0,       0,      3, 0, 3, 1, 2));
    vecs.push_back(v(0, 1, 1, 0,       0,      3, 0, 3, 0, 0));
    // Tick in START is dropped; tick+clear on a busy edge leaves count at 1.
    vecs.push_back(v(1, 1, 0, 0,       'b0001, 0, 1, 3, 0, 0));
    vecs.push_back(v(1, 1, 0, 0,       0,      0, 1, 3, 1, 1));
    vecs.push_back(v(1, 1, 1, 0,       0,      0, 1, 3, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, vecs[i].c, vecs[i].d, vecs[i].x);
    end

    // 300 dropped ticks saturate the counter.
    for (int i = 0; i < 300; i++) begin
      oc = (2 + i > 255) ? 255 : 2 + i;
      cyc("sat", 1, 1, 0, 0, mk(0, 0, 1, 3, 1, oc, 0));
    end
    finish_from("sat_fin", 0, 1, 3, 1, 255, 0);
    cyc("clr_sat", 0, 1, 1, 0, mk(0, 3, 0, 4, 0, 0, 0));

    // enable gating in IDLE and mid-pass deassertion.
    for (int i = 0; i < 3; i++) cyc("en0_idle", 1, 0, 0, 0, mk(0, 3, 0, 4, 0, 0, 0));
    cyc("en1_tick", 1, 1, 0, 0,      mk('b0001, 0, 1, 4, 0, 0, 0));
    cyc("en_wait0", 0, 1, 0, 0,      mk(0,      0, 1, 4, 0, 0, 0));
    cyc("en_s1",    0, 1, 0, 'b0001, mk('b0010, 1, 1, 4, 0, 0, 0));
    cyc("en_drop",  0, 0, 0, 0,      mk(0,      1, 1, 4, 0, 0, 0));
    finish_from("en_fin", 1, 0, 4, 0, 0, 0);
    cyc("en0_after", 1, 0, 0, 0, mk(0, 3, 0, 5, 0, 0, 0));

    // Asynchronous reset in WAIT of stage 2.
    cyc("rs_tick",  1, 1, 0, 0,      mk('b0001, 0, 1, 5, 0, 0, 0));
    cyc("rs_w0",    0, 1, 0, 0,      mk(0,      0, 1, 5, 0, 0, 0));
    cyc("rs_s1",    0, 1, 0, 'b0001, mk('b0010, 1, 1, 5, 0, 0, 0));
    cyc("rs_w1",    0, 1, 0, 0,      mk(0,      1, 1, 5, 0, 0, 0));
    cyc("rs_s2",    0, 1, 0, 'b0010, mk('b0100, 2, 1, 5, 0, 0, 0));
    cyc("rs_w2",    0, 1, 0, 0,      mk(0,      2, 1, 5, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    chk("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    chk("rst_hold");
    #2;
    rst = 1'b0;
    cyc("rs_stale_done", 0, 1, 0, 'b0100, mk(0,      0, 0, 0, 0, 0, 0));
    cyc("rs_restart",    1, 1, 0, 0,      mk('b0001, 0, 1, 0, 0, 0, 0));
    cyc("rs_rw0",        0, 1, 0, 0,      mk(0,      0, 1, 0, 0, 0, 0));
    finish_from("rs_fin", 0, 1, 0, 0, 0, 0);

`ifdef STAGE_TIMEOUT_EN
    // Stage 1 never answers: watchdog advances the pass.
    cyc("to_tick", 1, 1, 0, 0,      mk('b0001, 0, 1, 1, 0, 0, 0));
    cyc("to_w0",   0, 1, 0, 0,      mk(0,      0, 1, 1, 0, 0, 0));
    cyc("to_s1",   0, 1, 0, 'b0001, mk('b0010, 1, 1, 1, 0, 0, 0));
    for (int m = 1; m <= 17; m++) begin
      if (m < 17) cyc("to_wait", 0, 1, 0, 0, mk(0,      1, 1, 1, 0, 0, 0));
      else        cyc("to_fire", 0, 1, 0, 0, mk('b0100, 2, 1, 1, 0, 0, 1));
    end
    cyc("to_w2", 0, 1, 0, 0, mk(0, 2, 1, 1, 0, 0, 1));
    finish_from("to_fin", 2, 1, 1, 0, 0, 1);
    cyc("to_clr", 0, 1, 1, 0, mk(0, 3, 0, 2, 0, 0, 0));
    // Done on the limit edge is a normal completion.
    cyc("tod_tick", 1, 1, 0, 0, mk('b0001, 0, 1, 2, 0, 0, 0));
    for (int m = 1; m <= 17; m++) begin
      if (m < 17) cyc("tod_wait", 0, 1, 0, 0,      mk(0,      0, 1, 2, 0, 0, 0));
      else        cyc("tod_edge", 0, 1, 0, 'b0001, mk('b0010, 1, 1, 2, 0, 0, 0));
    end
    cyc("tod_w1", 0, 1, 0, 0, mk(0, 1, 1, 2, 0, 0, 0));
    finish_from("tod_fin", 1, 1, 2, 0, 0, 0);
`else
    // No watchdog: WAIT holds indefinitely and timeout_err stays 0.
    cyc("nt_tick", 1, 1, 0, 0, mk('b0001, 0, 1, 1, 0, 0, 0));
    for (int m = 1; m <= 25; m++) cyc("nt_wait", 0, 1, 0, 0, mk(0, 0, 1, 1, 0, 0, 0));
    cyc("nt_s1", 0, 1, 0, 'b0001, mk('b0010, 1, 1, 1, 0, 0, 0));
    cyc("nt_w1", 0, 1, 0, 0,      mk(0,      1, 1, 1, 0, 0, 0));
    finish_from("nt_fin", 1, 1, 1, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
